// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready handshakes and an iterative
// shift-add multiplier that holds the pipe for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ctl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero_eq,
    output logic               zero_ne
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);

    logic [1:0]         state;
    logic [SHAMT_W-1:0] counter;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;

    logic               accept;
    logic               is_mul;
    logic               is_sub;
    logic               lt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   acc_sum;

    // Reset forces in_ready low so nothing is consumed while rst is held.
    assign in_ready = rst &&
                      ((state == S_IDLE) || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign is_mul    = (ctl == OP_MUL);
    assign is_sub    = (ctl == OP_SUB);

    always_comb begin
        lt = 1'b0;
        if (SIGNED_SLT)
            lt = ($signed(a) < $signed(b));
        else
            lt = (a < b);
    end

    always_comb begin
        alu_res = '0;
        unique case (ctl)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SUB: alu_res = a + ~b + ONE;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_MUL: alu_res = '0;
        endcase
    end

    assign addend  = mplier[0] ? mcand : '0;
    assign acc_sum = acc + addend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            counter <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            result  <= '0;
            zero_eq <= 1'b0;
            zero_ne <= 1'b0;
        end else if (accept) begin
            zero_eq <= 1'b0;
            zero_ne <= 1'b0;
            if (is_mul) begin
                state   <= S_MUL;
                counter <= '0;
                acc     <= '0;
                mcand   <= a;
                mplier  <= b;
            end else begin
                state   <= S_DONE;
                result  <= alu_res;
                zero_eq <= is_sub && (alu_res == '0);
                zero_ne <= is_sub && (alu_res != '0);
            end
        end else begin
            case (state)
                S_MUL: begin
                    acc     <= acc_sum;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + SHAMT_W'(1);
                    // Last step lands straight in result, no extra cycle.
                    if (counter == CNT_LAST) begin
                        state  <= S_DONE;
                        result <= acc_sum;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state   <= S_IDLE;
                        zero_eq <= 1'b0;
                        zero_ne <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
